// File: rtl/servant_mtimer.sv
// servant_mtimer: prescaled free-running counter with NCH one-shot/periodic compare channels on Wishbone
module servant_mtimer #(
  parameter int WIDTH   = 32,
  parameter int NCH     = 2,
  parameter int PRESC_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);
  logic [WIDTH-1:0]   count, count_inc, wm, wd;
  logic [PRESC_W-1:0] pcnt, presc;
  logic               en, acc, wr, tick, wr_count, wr_ctrl, wr_pend, wr_ien;
  logic [NCH-1:0]     per, pend, ien, match;
  logic [WIDTH-1:0]   cmp [NCH];
  logic [WIDTH-1:0]   rld [NCH];
  logic [31:0]        wmask, ctrl, rd_ch, rd;

  assign acc       = i_wb_cyc & ~o_wb_ack;
  assign wr        = acc & i_wb_we;
  assign wr_count  = wr && i_wb_adr == 4'd0;
  assign wr_ctrl   = wr && i_wb_adr == 4'd1;
  assign wr_pend   = wr && i_wb_adr == 4'd2;
  assign wr_ien    = wr && i_wb_adr == 4'd3;
  assign tick      = en && pcnt == presc;
  assign count_inc = count + 1'b1;
  assign wmask     = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign wm        = wmask[WIDTH-1:0];
  assign wd        = i_wb_dat[WIDTH-1:0];
  assign o_irq     = |(pend & ien);

  // A software COUNT write suppresses both the increment and match evaluation
  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++)
      match[i] = tick & ~wr_count & (count_inc == cmp[i]);
  end

  // Read mux over register values as they stand before this edge
  always_comb begin
    ctrl = '0;
    ctrl[0] = en;
    ctrl[PRESC_W+7:8] = presc;
    ctrl[16+:NCH] = per;
    rd_ch = '0;
    for (int i = 0; i < NCH; i++)
      if (i_wb_adr[3] && i_wb_adr[2:1] == 2'(i))
        rd_ch = i_wb_adr[0] ? 32'(rld[i]) : 32'(cmp[i]);
    rd = i_wb_adr == 4'd0 ? 32'(count) :
         i_wb_adr == 4'd1 ? ctrl :
         i_wb_adr == 4'd2 ? 32'(pend) :
         i_wb_adr == 4'd3 ? 32'(ien) : rd_ch;
  end

  // Bus response, prescaler, counter and shared control/status registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      count    <= '0;
      pcnt     <= '0;
      en       <= 1'b0;
      presc    <= '0;
      per      <= '0;
      pend     <= '0;
      ien      <= '0;
    end else begin
      o_wb_ack <= acc;
      if (acc) o_wb_rdt <= rd;
      count <= wr_count ? (count & ~wm) | (wd & wm) : tick ? count_inc : count;
      pcnt  <= (wr_count || tick) ? '0 : en ? pcnt + 1'b1 : pcnt;
      if (wr_ctrl) begin
        en    <= wmask[0] ? i_wb_dat[0] : en;
        presc <= (presc & ~wmask[PRESC_W+7:8]) | (i_wb_dat[PRESC_W+7:8] & wmask[PRESC_W+7:8]);
        per   <= (per & ~wmask[16+:NCH]) | (i_wb_dat[16+:NCH] & wmask[16+:NCH]);
      end
      pend <= (pend & ~(wr_pend ? i_wb_dat[NCH-1:0] & wmask[NCH-1:0] : '0)) | match;
      if (wr_ien) ien <= (ien & ~wmask[NCH-1:0]) | (i_wb_dat[NCH-1:0] & wmask[NCH-1:0]);
    end
  end

  // Per-channel compare and reload; a software CMP write beats the periodic reload
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cmp[i] <= '0;
        rld[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cmp[i] <= (wr && i_wb_adr == 4'(8 + 2 * i)) ? (cmp[i] & ~wm) | (wd & wm) :
                  (match[i] & per[i]) ? cmp[i] + rld[i] : cmp[i];
        if (wr && i_wb_adr == 4'(9 + 2 * i)) rld[i] <= (rld[i] & ~wm) | (wd & wm);
      end
    end
  end
endmodule

// File: tb/tb_servant_mtimer.sv
// tb_servant_mtimer: scoreboard bench for servant_mtimer with WIDTH=8, NCH=2
module tb_servant_mtimer;
  logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0, cyc = 1'b0, ack, irq;
  logic [3:0]  adr = '0, sel = '0;
  logic [31:0] dat = '0, rdt;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q [$];

  servant_mtimer #(.WIDTH(8), .NCH(2), .PRESC_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One access: accepted at the next edge, ack seen one edge later, cyc held through the ack drop
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL ack_latency adr=%0d got=%0d exp=1", a, n); end
    if (!w) begin
      if (ack) begin
        checks++;
        if (rdt !== exp_q[0]) begin errors++; $display("FAIL read adr=%0d got=%h exp=%h", a, rdt, exp_q[0]); end
      end
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ack_pulse adr=%0d got=%b exp=0", a, ack); end
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    bus(1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hf);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
  endtask

  task automatic test_prescaler;
    wr(1, 32'h0000_0300);
    wr(0, 32'h0);
    wr(1, 32'h0000_0301);
    step(21);
    rd(0, 32'd5);
    step(2);
    wr(0, 32'h0);
    rd(0, 32'd0);
    step(1);
    rd(0, 32'd1);
    wr(1, 32'h0);
  endtask

  task automatic test_oneshot;
    wr(0, 32'h0); wr(8, 32'd10); wr(2, 32'h3); wr(3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_idle got=%b exp=0", irq); end
    wr(1, 32'h1);
    step(8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_early got=%b exp=0", irq); end
    step(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_fire got=%b exp=1", irq); end
    wr(2, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_w1c got=%b exp=0", irq); end
    step(253);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_norefire got=%b exp=0", irq); end
    step(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_wrap_refire got=%b exp=1", irq); end
    wr(1, 32'h0); wr(2, 32'h3); wr(3, 32'h0);
  endtask

  task automatic test_periodic;
    wr(0, 32'h0); wr(10, 32'd4); wr(11, 32'd6); wr(2, 32'h3); wr(3, 32'h2);
    wr(1, 32'h0002_0001);
    for (int m = 0; m < 3; m++) begin
      step(m == 0 ? 2 : 3);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL periodic_early m=%0d got=%b exp=0", m, irq); end
      step(1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL periodic_fire m=%0d got=%b exp=1", m, irq); end
      if (m < 2) begin
        wr(2, 32'h2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL periodic_clear m=%0d got=%b exp=0", m, irq); end
      end
    end
    wr(1, 32'h0002_0000);
    rd(10, 32'd22);
    rd(11, 32'd6);
    rd(0, 32'd17);
    wr(2, 32'h3); wr(3, 32'h0); wr(1, 32'h0);
  endtask

  task automatic test_simultaneous;
    wr(0, 32'h0); wr(8, 32'd5); wr(2, 32'h3); wr(3, 32'h1);
    wr(1, 32'h1);
    step(3);
    wr(2, 32'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b exp=1", irq); end
    rd(2, 32'h1);
    wr(1, 32'h0); wr(2, 32'h3); wr(3, 32'h0);
    wr(0, 32'h0); wr(8, 32'd1); wr(2, 32'h3);
    wr(1, 32'h0000_0301);
    step(2);
    wr(0, 32'd100);
    rd(0, 32'd100);
    rd(2, 32'h0);
    wr(1, 32'h0);
  endtask

  task automatic test_wrap_match;
    wr(0, 32'd250); wr(8, 32'h0); wr(2, 32'h3); wr(3, 32'h1);
    wr(1, 32'h1);
    step(4);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL wrap_early got=%b exp=0", irq); end
    step(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL wrap_fire got=%b exp=1", irq); end
    rd(0, 32'h0);
    wr(1, 32'h0); wr(2, 32'h3); wr(3, 32'h0);
  endtask

  task automatic test_byte_lanes;
    wr(1, 32'h0003_0001);
    bus(1'b1, 4'd1, 32'h0000_AB00, 4'b0010);
    rd(1, 32'h0003_AB01);
    wr(1, 32'hFFFF_FFFF);
    rd(1, 32'h0003_FF01);
    wr(1, 32'h0);
  endtask

  task automatic test_unmapped;
    wr(8, 32'h12);
    for (int a = 4; a < 8; a++) wr(4'(a), 32'hFFFF_FFFF);
    for (int a = 12; a < 16; a++) wr(4'(a), 32'hFFFF_FFFF);
    for (int a = 4; a < 8; a++) rd(4'(a), 32'h0);
    for (int a = 12; a < 16; a++) rd(4'(a), 32'h0);
    rd(8, 32'h12);
    wr(0, 32'hFFFF_FF37);
    rd(0, 32'h37);
  endtask

  task automatic test_reset_mid;
    cyc = 1'b1; we = 1'b1; adr = 4'd3; dat = 32'h3; sel = 4'hf; rst_n = 1'b0;
    step(1);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL reset_mid_ack got=%b exp=0", ack); end
    cyc = 1'b0; we = 1'b0; rst_n = 1'b1;
    rd(3, 32'h0);
  endtask

  initial begin
    test_reset;
    test_prescaler;
    test_oneshot;
    test_periodic;
    test_simultaneous;
    test_wrap_match;
    test_byte_lanes;
    test_unmapped;
    test_reset;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
